// File: rtl/link_list_engine.sv
// Linked-list engine over an external RAM: 2**TABLE_WIDTH list heads plus a node pool
// threaded onto a free list. Executes INSERT/DELETE/CHANGE/READ at a 0-based list position.
module link_list_engine #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int TABLE_WIDTH = 4,
    parameter int NODE_COUNT  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   order_valid,
    output logic                   order_busy,
    input  logic [1:0]             order_type,
    input  logic [TABLE_WIDTH-1:0] order_table,
    input  logic [ADDR_WIDTH-1:0]  order_node,
    input  logic [DATA_WIDTH-1:0]  order_data,
    output logic                   dout_valid,
    input  logic                   dout_busy,
    output logic [DATA_WIDTH-1:0]  dout_data,
    output logic [1:0]             dout_status,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    input  logic [DATA_WIDTH-1:0]  ram_read_data,
    output logic                   ram_write_req,
    output logic [DATA_WIDTH-1:0]  ram_write_data,
    output logic                   init_done,
    output logic [ADDR_WIDTH-1:0]  free_count,
    output logic [2:0]             dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(1 << TABLE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] NODES_A    = ADDR_WIDTH'(NODE_COUNT);
    localparam logic [ADDR_WIDTH-1:0] INIT_END_A = ADDR_WIDTH'((1 << TABLE_WIDTH) + NODE_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_CHANGE = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_FULL      = 2'b01;
    localparam logic [1:0] ST_NOT_FOUND = 2'b10;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_WALK = 3'd2,
        S_EXEC = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              phase, phase_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [ADDR_WIDTH-1:0]   init_next_ptr;
    logic [ADDR_WIDTH-1:0]   free_head;
    logic [1:0]              op_type;
    logic [ADDR_WIDTH-1:0]   op_node;
    logic [DATA_WIDTH-1:0]   op_data;
    logic [ADDR_WIDTH-1:0]   slot;
    logic [ADDR_WIDTH-1:0]   slot_val;
    logic [ADDR_WIDTH-1:0]   tgt;
    logic [DATA_WIDTH-1:0]   rdat;
    logic [ADDR_WIDTH-1:0]   step_cnt;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic                    accept;
    logic                    full_reject;
    logic                    walk_sample;
    logic                    walk_final;
    logic                    walk_miss;
    logic                    exec_done;

    // Handshake: a command moves on the clk edge where order_valid && !order_busy;
    // a response moves on the edge where dout_valid && !dout_busy.
    assign order_busy = (state != S_IDLE);
    assign dout_valid = (state == S_RESP);
    assign dbg_state  = state;

    assign rd_ptr      = ram_read_data[ADDR_WIDTH-1:0];
    assign accept      = (state == S_IDLE) && order_valid;
    assign full_reject = accept && (order_type == OP_INSERT) && (free_count == '0);
    assign walk_sample = (state == S_WALK) && phase[0];
    assign walk_final  = (step_cnt == op_node);
    assign walk_miss   = walk_sample &&
                         (walk_final ? ((op_type != OP_INSERT) && (rd_ptr == '0))
                                     : ((rd_ptr == '0) || (step_cnt >= NODES_A)));
    assign exec_done   = (state == S_EXEC) &&
                         ((phase == 3'd4) ||
                          ((phase == 3'd2) && ((op_type == OP_CHANGE) || (op_type == OP_READ))));

    // Next-pointer word of pool node (init_cnt - BASE): address 2*init_cnt - BASE + 1
    assign init_next_ptr = {init_cnt[ADDR_WIDTH-2:0], 1'b0} - BASE_A + ONE_A;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (init_cnt == INIT_END_A) state_nxt = S_IDLE;
            S_IDLE: if (accept) state_nxt = full_reject ? S_RESP : S_WALK;
            S_WALK: begin
                if (walk_miss)                      state_nxt = S_RESP;
                else if (walk_sample && walk_final) state_nxt = S_EXEC;
            end
            S_EXEC: if (exec_done) state_nxt = S_RESP;
            S_RESP: if (!dout_busy) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        phase_nxt = 3'd0;
        if (state_nxt == state) begin
            if (state == S_WALK)      phase_nxt = {2'b00, ~phase[0]};
            else if (state == S_EXEC) phase_nxt = phase + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            phase <= 3'd0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt       <= '0;
            init_done      <= 1'b0;
            free_head      <= '0;
            free_count     <= '0;
            op_type        <= OP_INSERT;
            op_node        <= '0;
            op_data        <= '0;
            slot           <= '0;
            slot_val       <= '0;
            tgt            <= '0;
            rdat           <= '0;
            step_cnt       <= '0;
            dout_data      <= '0;
            dout_status    <= ST_OK;
            ram_addr       <= '0;
            ram_write_req  <= 1'b0;
            ram_write_data <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt < BASE_A) begin
                        ram_write_req  <= 1'b1;
                        ram_addr       <= init_cnt;
                        ram_write_data <= '0;
                        init_cnt       <= init_cnt + ONE_A;
                    end else if (init_cnt < INIT_END_A) begin
                        ram_write_req  <= 1'b1;
                        ram_addr       <= init_next_ptr;
                        ram_write_data <= (init_cnt == INIT_END_A - ONE_A) ? '0
                                          : DATA_WIDTH'(init_next_ptr + ONE_A);
                        init_cnt       <= init_cnt + ONE_A;
                    end else begin
                        ram_write_req <= 1'b0;
                        ram_addr      <= '0;
                        init_done     <= 1'b1;
                        free_head     <= BASE_A;
                        free_count    <= NODES_A;
                    end
                end
                S_IDLE: begin
                    ram_write_req <= 1'b0;
                    if (accept) begin
                        op_type  <= order_type;
                        op_node  <= order_node;
                        op_data  <= order_data;
                        slot     <= ADDR_WIDTH'(order_table);
                        step_cnt <= '0;
                        ram_addr <= ADDR_WIDTH'(order_table);
                        if (full_reject) begin
                            dout_status <= ST_FULL;
                            dout_data   <= '0;
                        end
                    end
                end
                S_WALK: begin
                    if (walk_miss) begin
                        dout_status <= ST_NOT_FOUND;
                        dout_data   <= '0;
                    end else if (walk_sample && walk_final) begin
                        slot_val <= rd_ptr;
                        tgt      <= rd_ptr;
                        ram_addr <= (op_type == OP_INSERT) ? free_head + ONE_A : rd_ptr;
                    end else if (walk_sample) begin
                        slot     <= rd_ptr + ONE_A;
                        ram_addr <= rd_ptr + ONE_A;
                        step_cnt <= step_cnt + ONE_A;
                    end
                end
                S_EXEC: begin
                    // Reads (free_head.next or target data/next) complete before any write
                    case (phase)
                        3'd0: begin
                            if (op_type == OP_DELETE) ram_addr <= tgt + ONE_A;
                        end
                        3'd1: begin
                            rdat <= ram_read_data;
                            if (op_type == OP_INSERT) begin
                                ram_write_req  <= 1'b1;
                                ram_addr       <= free_head;
                                ram_write_data <= op_data;
                            end else if (op_type == OP_CHANGE) begin
                                ram_write_req  <= 1'b1;
                                ram_addr       <= tgt;
                                ram_write_data <= op_data;
                            end
                        end
                        3'd2: begin
                            if (op_type == OP_INSERT) begin
                                ram_write_req  <= 1'b1;
                                ram_addr       <= free_head + ONE_A;
                                ram_write_data <= DATA_WIDTH'(slot_val);
                            end else if (op_type == OP_DELETE) begin
                                ram_write_req  <= 1'b1;
                                ram_addr       <= slot;
                                ram_write_data <= ram_read_data;
                            end else begin
                                ram_write_req <= 1'b0;
                                dout_status   <= ST_OK;
                                dout_data     <= rdat;
                            end
                        end
                        3'd3: begin
                            ram_write_req <= 1'b1;
                            if (op_type == OP_INSERT) begin
                                ram_addr       <= slot;
                                ram_write_data <= DATA_WIDTH'(free_head);
                            end else begin
                                ram_addr       <= tgt + ONE_A;
                                ram_write_data <= DATA_WIDTH'(free_head);
                            end
                        end
                        default: begin
                            ram_write_req <= 1'b0;
                            dout_status   <= ST_OK;
                            if (op_type == OP_INSERT) begin
                                free_head  <= rdat[ADDR_WIDTH-1:0];
                                free_count <= free_count - ONE_A;
                                dout_data  <= DATA_WIDTH'(free_head);
                            end else begin
                                free_head  <= tgt;
                                free_count <= free_count + ONE_A;
                                dout_data  <= rdat;
                            end
                        end
                    endcase
                end
                S_RESP: begin
                    ram_write_req <= 1'b0;
                end
                default: begin
                    ram_write_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_list_engine.sv
// Directed bench for link_list_engine: behavioural RAM, a table of command vectors with
// hand-computed results, and hand sequences for busy hold, pool exhaustion and mid-op reset.
module tb_link_list_engine;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int NC = 64;

    localparam logic [1:0] INS = 2'b00, DEL = 2'b01, CHG = 2'b10, RD = 2'b11;
    localparam logic [1:0] OK = 2'b00, FULL_ST = 2'b01, NF = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          order_valid, order_busy;
    logic [1:0]    order_type;
    logic [TW-1:0] order_table;
    logic [AW-1:0] order_node;
    logic [DW-1:0] order_data;
    logic          dout_valid, dout_busy;
    logic [DW-1:0] dout_data;
    logic [1:0]    dout_status;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_read_data;
    logic          ram_write_req;
    logic [DW-1:0] ram_write_data;
    logic          init_done;
    logic [AW-1:0] free_count;
    logic [2:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    link_list_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TABLE_WIDTH(TW), .NODE_COUNT(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .order_valid(order_valid), .order_busy(order_busy), .order_type(order_type),
        .order_table(order_table), .order_node(order_node), .order_data(order_data),
        .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
        .dout_status(dout_status), .ram_addr(ram_addr), .ram_read_data(ram_read_data),
        .ram_write_req(ram_write_req), .ram_write_data(ram_write_data),
        .init_done(init_done), .free_count(free_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // RAM model: write on the edge, registered read; contents start as garbage
    logic [DW-1:0] mem [0:255];
    logic          mem_ready = 1'b0;
    int            wr_cnt = 0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD ^ 16'(i);
            mem_ready <= 1'b1;
        end else begin
            if (ram_write_req) begin
                mem[ram_addr[7:0]] <= ram_write_data;
                wr_cnt <= wr_cnt + 1;
            end
            ram_read_data <= mem[ram_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        n_vec++;
        if (act > lim) begin
            n_err++;
            $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (order_busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (order_busy) chk({name, " idle timeout"}, 32'(order_busy), 32'd0);
    endtask

    // One command: accept, scramble the inputs, wait for the response, then handshake it
    task automatic do_cmd(input string name, input logic [1:0] ty, input logic [TW-1:0] tbl,
                          input logic [AW-1:0] nd, input logic [DW-1:0] dt,
                          output logic [DW-1:0] rdata, output logic [1:0] rstat,
                          output int lat, output int wr_delta);
        int wr0;
        @(negedge clk);
        wait_idle(name);
        wr0         = wr_cnt;
        order_valid = 1'b1;
        order_type  = ty;
        order_table = tbl;
        order_node  = nd;
        order_data  = dt;
        @(posedge clk);
        @(negedge clk);
        order_valid = 1'b0;
        order_type  = 2'($urandom_range(0, 3));
        order_table = TW'($urandom_range(0, 15));
        order_node  = AW'($urandom_range(0, 7));
        order_data  = DW'($urandom_range(0, 65535));
        lat = 0;
        while (!dout_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " response timeout"}, 32'(dout_valid), 32'd1);
        rdata    = dout_data;
        rstat    = dout_status;
        wr_delta = wr_cnt - wr0;
        @(posedge clk);
    endtask

    typedef struct {
        logic [1:0]    ty;
        logic [TW-1:0] tbl;
        logic [AW-1:0] node;
        logic [DW-1:0] data;
        logic [1:0]    st;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_free;
    } vec_t;

    vec_t vt [25];

    function automatic int exp_writes(input logic [1:0] ty, input logic [1:0] st);
        if (st != OK) return 0;
        case (ty)
            INS: return 3;
            DEL: return 2;
            CHG: return 1;
            default: return 0;
        endcase
    endfunction

    initial begin
        logic [DW-1:0] rdata;
        logic [1:0]    rstat;
        logic [DW-1:0] held;
        int            lat, wrd, wr0, cyc, spurious;

        order_valid = 1'b0; order_type = INS; order_table = '0; order_node = '0;
        order_data = '0; dout_busy = 1'b0;

        vt[0]  = '{INS, 4'd2, 16'd0, 16'h1111, OK, 16'd16,   16'd63};
        vt[1]  = '{INS, 4'd2, 16'd1, 16'h2222, OK, 16'd18,   16'd62};
        vt[2]  = '{INS, 4'd2, 16'd2, 16'h3333, OK, 16'd20,   16'd61};
        vt[3]  = '{RD,  4'd2, 16'd1, 16'h0000, OK, 16'h2222, 16'd61};
        vt[4]  = '{RD,  4'd2, 16'd0, 16'h0000, OK, 16'h1111, 16'd61};
        vt[5]  = '{RD,  4'd2, 16'd2, 16'h0000, OK, 16'h3333, 16'd61};
        vt[6]  = '{RD,  4'd2, 16'd3, 16'h0000, NF, 16'h0000, 16'd61};
        vt[7]  = '{RD,  4'd3, 16'd0, 16'h0000, NF, 16'h0000, 16'd61};
        vt[8]  = '{DEL, 4'd2, 16'd0, 16'h0000, OK, 16'h1111, 16'd62};
        vt[9]  = '{RD,  4'd2, 16'd0, 16'h0000, OK, 16'h2222, 16'd62};
        vt[10] = '{INS, 4'd5, 16'd0, 16'h5555, OK, 16'd16,   16'd61};
        vt[11] = '{CHG, 4'd2, 16'd1, 16'h7777, OK, 16'h3333, 16'd61};
        vt[12] = '{RD,  4'd2, 16'd1, 16'h0000, OK, 16'h7777, 16'd61};
        vt[13] = '{INS, 4'd2, 16'd1, 16'h4444, OK, 16'd22,   16'd60};
        vt[14] = '{RD,  4'd2, 16'd1, 16'h0000, OK, 16'h4444, 16'd60};
        vt[15] = '{RD,  4'd2, 16'd2, 16'h0000, OK, 16'h7777, 16'd60};
        vt[16] = '{INS, 4'd5, 16'd1, 16'h6666, OK, 16'd24,   16'd59};
        vt[17] = '{RD,  4'd5, 16'd5, 16'h0000, NF, 16'h0000, 16'd59};
        vt[18] = '{DEL, 4'd5, 16'd2, 16'h0000, NF, 16'h0000, 16'd59};
        vt[19] = '{DEL, 4'd2, 16'd2, 16'h0000, OK, 16'h7777, 16'd60};
        vt[20] = '{RD,  4'd2, 16'd2, 16'h0000, NF, 16'h0000, 16'd60};
        vt[21] = '{INS, 4'd2, 16'd3, 16'h9999, NF, 16'h0000, 16'd60};
        vt[22] = '{INS, 4'd2, 16'd2, 16'h8888, OK, 16'd20,   16'd59};
        vt[23] = '{RD,  4'd2, 16'd2, 16'h0000, OK, 16'h8888, 16'd59};
        vt[24] = '{RD,  4'd5, 16'd1, 16'h0000, OK, 16'h6666, 16'd59};

        // ---- reset and init ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst order_busy", 32'(order_busy), 32'd1);
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst dout_valid", 32'(dout_valid), 32'd0);
        chk("rst ram_write_req", 32'(ram_write_req), 32'd0);
        chk("rst free_count", 32'(free_count), 32'd0);
        chk("rst dout_data", 32'(dout_data), 32'd0);
        repeat (3) @(negedge clk);
        wr0   = wr_cnt;
        rst_n = 1'b1;
        cyc   = 0;
        while (!init_done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("init writes", 32'(wr_cnt - wr0), 32'd80);
        chk("init free_count", 32'(free_count), 32'd64);
        chk("init head3", 32'(mem[3]), 32'd0);
        chk("init node0 next", 32'(mem[17]), 32'd18);
        chk("init last next", 32'(mem[143]), 32'd0);
        chk("init idle state", 32'(dbg_state), 32'd1);

        // ---- vector table ----
        for (int i = 0; i < 25; i++) begin
            do_cmd($sformatf("v%0d", i), vt[i].ty, vt[i].tbl, vt[i].node, vt[i].data,
                   rdata, rstat, lat, wrd);
            chk($sformatf("v%0d status", i), 32'(rstat), 32'(vt[i].st));
            chk($sformatf("v%0d data", i), 32'(rdata), 32'(vt[i].exp_data));
            chk($sformatf("v%0d free_count", i), 32'(free_count), 32'(vt[i].exp_free));
            chk($sformatf("v%0d writes", i), 32'(wrd), 32'(exp_writes(vt[i].ty, vt[i].st)));
            chk_le($sformatf("v%0d latency", i), lat, 2 * int'(vt[i].node) + 10);
        end

        // ---- response held by dout_busy; new order ignored meanwhile ----
        @(negedge clk);
        wait_idle("hold");
        wr0 = wr_cnt;
        dout_busy = 1'b1;
        order_valid = 1'b1; order_type = RD; order_table = 4'd2; order_node = 16'd0;
        @(posedge clk);
        @(negedge clk);
        order_type = INS; order_table = 4'd2; order_node = 16'd0; order_data = 16'hABCD;
        cyc = 0;
        while (!dout_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        held = dout_data;
        chk("hold first data", 32'(held), 32'h2222);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold valid c%0d", i), 32'(dout_valid), 32'd1);
            chk($sformatf("hold data c%0d", i), 32'(dout_data), 32'h2222);
            chk($sformatf("hold busy c%0d", i), 32'(order_busy), 32'd1);
        end
        order_valid = 1'b0;
        dout_busy   = 1'b0;
        @(negedge clk);
        chk("release order_busy", 32'(order_busy), 32'd0);
        chk("release dout_valid", 32'(dout_valid), 32'd0);
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (dout_valid || order_busy) spurious++;
        end
        chk("hold no extra cmd", 32'(spurious), 32'd0);
        chk("hold free_count", 32'(free_count), 32'd59);
        chk("hold writes", 32'(wr_cnt - wr0), 32'd0);

        // ---- exhaust the pool, then FULL ----
        for (int i = 0; i < 59; i++) begin
            do_cmd("fill", INS, 4'd7, 16'd0, 16'(16'h0100 + i), rdata, rstat, lat, wrd);
            if (i == 0 || i == 58) chk($sformatf("fill %0d status", i), 32'(rstat), 32'(OK));
        end
        chk("pool empty", 32'(free_count), 32'd0);
        do_cmd("full", INS, 4'd7, 16'd0, 16'h5A5A, rdata, rstat, lat, wrd);
        chk("full status", 32'(rstat), 32'(FULL_ST));
        chk("full data", 32'(rdata), 32'd0);
        chk("full writes", 32'(wrd), 32'd0);
        chk("full free_count", 32'(free_count), 32'd0);
        chk_le("full latency", lat, 2);
        do_cmd("full rd", RD, 4'd7, 16'd0, 16'h0, rdata, rstat, lat, wrd);
        chk("last fill data", 32'(rdata), 32'h013A);

        // ---- reset in the middle of a command ----
        @(negedge clk);
        wait_idle("midrst");
        order_valid = 1'b1; order_type = DEL; order_table = 4'd7; order_node = 16'd3;
        @(posedge clk);
        @(negedge clk);
        order_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst order_busy", 32'(order_busy), 32'd1);
        chk("midrst init_done", 32'(init_done), 32'd0);
        chk("midrst free_count", 32'(free_count), 32'd0);
        chk("midrst ram_write_req", 32'(ram_write_req), 32'd0);
        chk("midrst dout_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!init_done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reinit done", 32'(init_done), 32'd1);
        chk("reinit free_count", 32'(free_count), 32'd64);
        do_cmd("reinit rd2", RD, 4'd2, 16'd0, 16'h0, rdata, rstat, lat, wrd);
        chk("reinit t2 empty", 32'(rstat), 32'(NF));
        do_cmd("reinit rd7", RD, 4'd7, 16'd0, 16'h0, rdata, rstat, lat, wrd);
        chk("reinit t7 empty", 32'(rstat), 32'(NF));
        do_cmd("reinit ins", INS, 4'd7, 16'd0, 16'hBEEF, rdata, rstat, lat, wrd);
        chk("reinit first node", 32'(rdata), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
